// File: rtl/switch_pkg.sv
// Shared constants for the switch debouncer: debounce lengths for simulation and board
// builds, and the channel indices that map onto the downstream x1/x2 inputs.
package switch_pkg;

    localparam int SIM_DEBOUNCE   = 4;
    localparam int BOARD_DEBOUNCE = 50000;

    localparam int CH_X1 = 0;
    localparam int CH_X2 = 1;

    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_CNT_W       = 16;

    // Largest debounce length a counter of the given width can hold.
    function automatic longint max_debounce(input int cnt_w);
        return (longint'(1) << cnt_w) - 1;
    endfunction

endpackage : switch_pkg

// File: rtl/debounce_channel.sv
// One switch channel: multi-flop synchronizer, stability counter, debounced level and
// single-cycle rise/fall pulses registered together with the level change.
module debounce_channel
    import switch_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = BOARD_DEBOUNCE,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("debounce_channel: SYNC_STAGES must be in 2..4");
    end
    if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > max_debounce(CNT_W)) begin : g_bad_cnt
        $error("debounce_channel: DEBOUNCE_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Any sample that agrees with the current level restarts the count from zero.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            cnt_d   = '0;
            level_d = sync;
            rise_d  = sync;
            fall_d  = ~sync;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign busy  = |cnt_q;

endmodule : debounce_channel

// File: rtl/switch_debouncer.sv
// Debounces NCH raw board switches into clean levels for the x1/x2 test logic inputs,
// with per-channel edge pulses and a shared busy flag.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int NCH             = 2,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = BOARD_DEBOUNCE,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] sw_raw,
    output logic [NCH-1:0] sw_level,
    output logic [NCH-1:0] sw_rise,
    output logic [NCH-1:0] sw_fall,
    output logic           busy
);

    logic [NCH-1:0] ch_busy;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (sw_raw[i]),
            .level(sw_level[i]),
            .rise (sw_rise[i]),
            .fall (sw_fall[i]),
            .busy (ch_busy[i])
        );
    end

    // Each channel's busy is decoded straight from its counter register.
    assign busy = |ch_busy;

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random switch activity, checked
// against a sample-window reference model through an expected-output queue.
module tb_switch_debouncer;
  import switch_pkg::*;

  localparam int NCH  = 2;
  localparam int SYNC = 2;
  localparam int DC   = SIM_DEBOUNCE;
  localparam int W    = 3 * NCH + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [NCH-1:0] sw_raw = '0;
  logic [NCH-1:0] sw_level, sw_rise, sw_fall;
  logic           busy;

  switch_debouncer #(
    .NCH            (NCH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_raw  (sw_raw),
    .sw_level(sw_level),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .busy    (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0]   exp_q[$];
  int             n_cmp = 0;
  int             n_bad = 0;

  // reference model: raw samples reach the decision logic SYNC edges later; a level flips
  // once the last DC samples since the previous flip all disagree with it
  logic [NCH-1:0] pipe_q[$];
  logic [NCH-1:0] hist_q[$];
  int             edge_n;
  int             last_flip[NCH];
  logic [NCH-1:0] m_level;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    pipe_q.delete();
    hist_q.delete();
    for (int i = 0; i < SYNC; i++) pipe_q.push_back('0);
    edge_n  = 0;
    m_level = '0;
    for (int c = 0; c < NCH; c++) last_flip[c] = 0;
  endtask

  task automatic model_edge(input logic [NCH-1:0] v);
    logic [NCH-1:0] u, rise, fall, bsy;
    bit             all_diff;
    edge_n++;
    pipe_q.push_back(v);
    u = pipe_q.pop_front();
    hist_q.push_back(u);
    if (hist_q.size() > DC) void'(hist_q.pop_front());
    rise = '0;
    fall = '0;
    bsy  = '0;
    for (int c = 0; c < NCH; c++) begin
      all_diff = (edge_n - last_flip[c] >= DC);
      if (all_diff)
        for (int j = 0; j < DC; j++)
          if (hist_q[hist_q.size() - 1 - j][c] == m_level[c]) all_diff = 0;
      if (all_diff) begin
        m_level[c]   = u[c];
        last_flip[c] = edge_n;
        rise[c]      = u[c];
        fall[c]      = ~u[c];
      end else begin
        bsy[c] = (u[c] != m_level[c]);
      end
    end
    exp_q.push_back({m_level, rise, fall, |bsy});
  endtask

  // driver tasks
  task automatic drive(input logic [NCH-1:0] v, input int n);
    repeat (n) begin
      sw_raw = v;
      @(posedge clk);
      model_edge(v);
      #1;
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {sw_level, sw_rise, sw_fall, busy}, '0);
  endtask

  task automatic pulse_reset(input logic [NCH-1:0] v, input int n);
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    sw_raw = v;
    #1;
    check_zero("async_reset");
    repeat (n) begin
      @(negedge clk);
      check_zero("held_reset");
    end
    #2;
    exp_q.delete();
    model_reset();
    rst_n = 1'b1;
    #1;
  endtask

  // monitor: compares every registered cycle, plus pulse-shape invariants
  logic [NCH-1:0] prev_level = '0, prev_rise = '0, prev_fall = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_level <= '0;
      prev_rise  <= '0;
      prev_fall  <= '0;
    end else if (exp_q.size() > 0) begin
      check("outputs", {sw_level, sw_rise, sw_fall, busy}, exp_q.pop_front());
      check("rise_and_fall", W'(sw_rise & sw_fall), '0);
      check("pulse_twice", W'((sw_rise & prev_rise) | (sw_fall & prev_fall)), '0);
      check("level_vs_pulse", W'(sw_level ^ prev_level), W'(sw_rise | sw_fall));
      prev_level <= sw_level;
      prev_rise  <= sw_rise;
      prev_fall  <= sw_fall;
    end
  end

  // stimulus
  initial begin
    model_reset();
    sw_raw = 2'b11;
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("power_on_reset");
    repeat (3) begin
      @(negedge clk);
      check_zero("held_reset");
    end
    #2;
    model_reset();
    rst_n = 1'b1;
    #1;

    // both channels high through reset, then clean simultaneous fall
    drive(2'b11, 10);
    drive(2'b00, 10);
    // clean rise and fall on ch0
    drive(2'b01, 10);
    drive(2'b00, 10);
    // glitch on ch0 shorter than the debounce window
    drive(2'b01, 3);
    drive(2'b00, 10);
    // ch1 bounces every 2 clocks, then settles high
    for (int i = 0; i < 5; i++) begin
      drive(2'b10, 2);
      drive(2'b00, 2);
    end
    drive(2'b10, 12);
    // bring ch0 up too, then both fall together
    drive(2'b11, 10);
    drive(2'b00, 10);
    // reset while ch0 has a count pending, raw held high through reset
    drive(2'b01, 3);
    pulse_reset(2'b11, 2);
    drive(2'b11, 10);

    // random switch activity with variable hold lengths
    for (int b = 0; b < 80; b++) begin
      logic [NCH-1:0] v;
      v = NCH'($urandom_range(0, 3));
      drive(v, $urandom_range(1, 9));
      if (b == 40) pulse_reset(NCH'($urandom_range(0, 3)), $urandom_range(1, 3));
    end
    drive(sw_raw, 10);

    @(negedge clk);
    #1;
    check("queue_drained", W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_switch_debouncer
